// File: rtl/sync_debounce_edge.sv
// Debounces a pre-synchronised level and emits registered rise/fall strobes.
// Optional accepted-rise counter enabled by SYNC_DEBOUNCE_EVT_CNT_EN.
module sync_debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             out,
  output logic             rise,
  output logic             fall
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  ,
  output logic [CNT_W-1:0] evt_cnt
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535 || CNT_W < 1) begin : g_bad
    $error("sync_debounce_edge: illegal parameters");
  end

  typedef enum logic [1:0] {
    LOW_STABLE,
    CHK_HIGH,
    HIGH_STABLE,
    CHK_LOW
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            out_q, out_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      LOW_STABLE: begin
        if (in) begin
          state_d = CHK_HIGH;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      CHK_HIGH: begin
        if (!in) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
          out_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      HIGH_STABLE: begin
        if (!in) begin
          state_d = CHK_LOW;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      CHK_LOW: begin
        if (in) begin
          state_d = HIGH_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = LOW_STABLE;
          cnt_d   = '0;
          out_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOW_STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
  logic [CNT_W-1:0] evt_cnt_q;

  // Wraps freely; counts on the same edge rise is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_cnt_q <= '0;
    end else if (rise_d) begin
      evt_cnt_q <= evt_cnt_q + CNT_W'(1);
    end
  end

  assign evt_cnt = evt_cnt_q;
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Self-checking bench for sync_debounce_edge (STABLE_CYCLES=4, CNT_W=2).
module tb_sync_debounce_edge;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_s = 1'b0;
  logic       out_s, rise_s, fall_s;
  logic [1:0] evt_s;

  sync_debounce_edge #(.STABLE_CYCLES(N), .CNT_W(2)) dut (
    .clk  (clk),
    .rst  (rst_n),
    .in   (in_s),
    .out  (out_s),
    .rise (rise_s),
    .fall (fall_s)
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
    ,
    .evt_cnt(evt_s)
`endif
  );

`ifndef SYNC_DEBOUNCE_EVT_CNT_EN
  assign evt_s = 2'b00;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic o;
    logic r;
    logic f;
    logic [1:0] e;
  } exp_t;

  typedef struct {
    logic i;
    logic o;
    logic r;
    logic f;
  } vec_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   rise_seen = 0;

  logic       m_out = 1'b0;
  logic       m_rise = 1'b0;
  logic       m_fall = 1'b0;
  logic [1:0] m_evt = 2'b00;
  int         m_run = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Run-length reference: count consecutive samples differing from out.
  task automatic model_step(input logic v);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (v != m_out) begin
      m_run++;
      if (m_run == N) begin
        m_out  = v;
        m_rise = v;
        m_fall = !v;
        m_run  = 0;
        if (v) m_evt = m_evt + 2'd1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic model_reset();
    m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_evt = 2'b00; m_run = 0;
  endtask

  task automatic cycle(input string name, input logic v, input bit tab,
                       input logic eo, input logic er, input logic ef);
    exp_t x;
    exp_t y;
    @(negedge clk);
    in_s = v;
    model_step(v);
    x.o = tab ? eo : m_out;
    x.r = tab ? er : m_rise;
    x.f = tab ? ef : m_fall;
    x.e = m_evt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 4'h1, 4'h0);
    end else begin
      y = sb.pop_front();
      chk(name, {1'b0, out_s, rise_s, fall_s}, {1'b0, y.o, y.r, y.f});
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
      chk({name, "_evt"}, {2'b00, evt_s}, {2'b00, y.e});
`endif
    end
    if (rise_s === 1'b1) rise_seen++;
  endtask

  task automatic mcycle(input string name, input logic v);
    cycle(name, v, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset(input string name);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({name, "_async"}, {evt_s, rise_s, fall_s} == 4'h0 ? {3'b000, out_s} : 4'hf, 4'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  vec_t       vt[10];
  logic [1:0] evt_tab[5];

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vt[9] = '{1'b0, 1'b0, 1'b0, 1'b0};
    evt_tab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    #12;
    chk("reset_state", {evt_s, rise_s, fall_s} == 4'h0 ? {3'b000, out_s} : 4'hf, 4'h0);
    #5;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) mcycle("t1_hold_low", 1'b0);

    for (int i = 0; i < 3; i++) mcycle("t2_short_high", 1'b1);
    for (int i = 0; i < 4; i++) mcycle("t2_back_low", 1'b0);

    for (int i = 0; i < 10; i++)
      cycle($sformatf("t3_vec%0d", i), vt[i].i, 1'b1, vt[i].o, vt[i].r, vt[i].f);

    rise_seen = 0;
    for (int i = 0; i < 50; i++) mcycle("t4_toggle", logic'(i % 2));
    chk("t4_no_rise_toggle", 4'(rise_seen), 4'h0);
    for (int i = 0; i < 6; i++) mcycle("t4_held", 1'b1);
    chk("t4_one_rise", 4'(rise_seen), 4'h1);

    mcycle("t5_pre", 1'b1);
    mcycle("t5_pre", 1'b1);
    pulse_reset("t5_rst");
    for (int i = 0; i < 6; i++) mcycle("t5_fresh", 1'b1);

    pulse_reset("t6_rst");
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 6; i++) mcycle("t6_high", 1'b1);
`ifdef SYNC_DEBOUNCE_EVT_CNT_EN
      chk($sformatf("t6_evt_pulse%0d", p), {2'b00, evt_s}, {2'b00, evt_tab[p]});
`endif
      for (int i = 0; i < 6; i++) mcycle("t6_low", 1'b0);
    end

    for (int i = 0; i < 40; i++) mcycle("t7_random", logic'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
